// File: rtl/sm_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sm_mem_arbiter
// Description : Shares one single-port synchronous RAM between the schoolMIPS
//               fetch (I) and data (D) ports. D has priority, bounded by a
//               starvation limit. Optional statistics via SM_ARB_STAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sm_mem_arbiter #(
    parameter int AW    = 8,
    parameter int D_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [31:0]   i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_ack,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata,
`ifdef SM_ARB_STAT_EN
    output logic [15:0]   stat_conf,
    output logic [15:0]   stat_istall,
`endif
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_I_ACC = 2'd1,
        ST_D_ACC = 2'd2
    } state_t;

    localparam logic [3:0] C_DCNT_MAX = 4'(D_MAX);

    state_t     r_state_q, w_state_d;
    logic [3:0] r_dcnt_q,  w_dcnt_d;

    logic w_i_ack, w_d_ack;
    logic w_i_elig, w_d_elig;
    logic w_grant_i, w_grant_d;

    // Outputs are gated by rst so an access in flight at reset never acks.
    always_comb begin
        w_i_ack   = !rst && (r_state_q == ST_I_ACC);
        w_d_ack   = !rst && (r_state_q == ST_D_ACC);
        w_i_elig  = i_req && !w_i_ack;
        w_d_elig  = d_req && !w_d_ack;
        w_grant_d = !rst && w_d_elig && !(w_i_elig && (r_dcnt_q == C_DCNT_MAX));
        w_grant_i = !rst && w_i_elig && !w_grant_d;
    end

    always_comb begin
        w_state_d = ST_IDLE;
        w_dcnt_d  = r_dcnt_q;
        if (w_grant_d) begin
            w_state_d = ST_D_ACC;
        end else if (w_grant_i) begin
            w_state_d = ST_I_ACC;
        end
        if (w_grant_d && w_i_elig) begin
            if (r_dcnt_q < C_DCNT_MAX) begin
                w_dcnt_d = r_dcnt_q + 4'd1;
            end
        end else if (w_grant_i || !w_i_elig) begin
            w_dcnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_dcnt_q  <= 4'd0;
        end else begin
            r_state_q <= w_state_d;
            r_dcnt_q  <= w_dcnt_d;
        end
    end

    always_comb begin
        i_ack   = w_i_ack;
        d_ack   = w_d_ack;
        i_rdata = w_i_ack ? m_rdata : 32'd0;
        d_rdata = w_d_ack ? m_rdata : 32'd0;
        busy    = !rst && (r_state_q != ST_IDLE);
        m_en    = w_grant_d || w_grant_i;
        m_we    = w_grant_d && d_we;
        m_wdata = w_grant_d ? d_wdata : 32'd0;
        m_addr  = '0;
        if (w_grant_d) begin
            m_addr = d_addr;
        end else if (w_grant_i) begin
            m_addr = i_addr;
        end
    end

`ifdef SM_ARB_STAT_EN
    logic [15:0] r_stat_conf_q,   w_stat_conf_d;
    logic [15:0] r_stat_istall_q, w_stat_istall_d;

    always_comb begin
        w_stat_conf_d   = r_stat_conf_q;
        w_stat_istall_d = r_stat_istall_q;
        if (w_i_elig && w_d_elig && (r_stat_conf_q != 16'hFFFF)) begin
            w_stat_conf_d = r_stat_conf_q + 16'd1;
        end
        if (w_i_elig && !w_grant_i && (r_stat_istall_q != 16'hFFFF)) begin
            w_stat_istall_d = r_stat_istall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_conf_q   <= 16'd0;
            r_stat_istall_q <= 16'd0;
        end else begin
            r_stat_conf_q   <= w_stat_conf_d;
            r_stat_istall_q <= w_stat_istall_d;
        end
    end

    assign stat_conf   = r_stat_conf_q;
    assign stat_istall = r_stat_istall_q;
`endif

endmodule
`default_nettype wire
